// File: rtl/if_id_stall_reg.sv
// IF/ID pipeline register: holds on load-use stalls, loads NOP on branch flushes and flags runaway stalls.
// Optional build macro HAZ_PERF_EN adds saturating stall_count/flush_count event counters.
module if_id_stall_reg #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] NOP_INSTR    = 32'h00000013,
  parameter int              FLUSH_CYCLES = 1,
  parameter int              MAX_STALL    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  input  logic            valid_in,
  input  logic            SignalPC,
  input  logic            flush,
  output logic            pc_write,
  output logic            if_id_write,
  output logic            bubble_ex,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] instr_out,
  output logic            valid_out,
  output logic            stall_err
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]     stall_count,
  output logic [31:0]     flush_count
`endif
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] STALL_LIMIT  = 8'(MAX_STALL);

  state_t          state_q;
  state_t          state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] instr_d;
  logic            valid_q;
  logic            valid_d;
  logic            err_q;
  logic            err_d;
  logic [3:0]      flush_cnt_q;
  logic [3:0]      flush_cnt_d;
  logic [7:0]      stall_cnt_q;
  logic [7:0]      stall_cnt_d;
  logic            stall_eff;

  // A flush outranks a stall request, and stall requests are ignored while flushing.
  assign stall_eff   = SignalPC & (state_q != FLUSH) & ~flush;
  assign pc_write    = ~stall_eff;
  assign if_id_write = ~stall_eff;
  assign bubble_ex   = stall_eff | flush;

  assign pc_out    = pc_q;
  assign instr_out = instr_q;
  assign valid_out = valid_q;
  assign stall_err = err_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    err_d       = err_q;
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      instr_d     = NOP_INSTR;
      valid_d     = 1'b0;
      flush_cnt_d = FLUSH_RELOAD;
      stall_cnt_d = 8'd0;
      state_d     = FLUSH;
    end else begin
      case (state_q)
        RUN: begin
          if (SignalPC) begin
            stall_cnt_d = 8'd1;
            state_d     = STALL;
          end else begin
            pc_d    = pc_in;
            instr_d = instr_in;
            valid_d = valid_in;
          end
        end
        STALL: begin
          if (SignalPC) begin
            if (stall_cnt_q != 8'hFF) begin
              stall_cnt_d = stall_cnt_q + 8'd1;
            end
          end else begin
            pc_d        = pc_in;
            instr_d     = instr_in;
            valid_d     = valid_in;
            stall_cnt_d = 8'd0;
            state_d     = RUN;
          end
        end
        FLUSH: begin
          if (flush_cnt_q == 4'd0) begin
            pc_d    = pc_in;
            instr_d = instr_in;
            valid_d = valid_in;
            state_d = RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 4'd1;
          end
        end
        default: state_d = RUN;
      endcase
      if (stall_eff && (stall_cnt_d >= STALL_LIMIT)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= '0;
      instr_q     <= NOP_INSTR;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      flush_cnt_q <= 4'd0;
      stall_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] stall_count_q;
  logic [31:0] stall_count_d;
  logic [31:0] flush_count_q;
  logic [31:0] flush_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall_eff && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
    if (flush && (flush_count_q != 32'hFFFF_FFFF)) begin
      flush_count_d = flush_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_if_id_stall_reg.sv
// Bench for if_id_stall_reg: dut0 uses FLUSH_CYCLES=1, dut1 uses FLUSH_CYCLES=2; both share stimulus.
module tb_if_id_stall_reg;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        valid_in;
  logic        sig_pc;
  logic        flush;

  logic        pw_o  [2];
  logic        iw_o  [2];
  logic        bx_o  [2];
  logic [31:0] pc_o  [2];
  logic [31:0] in_o  [2];
  logic        v_o   [2];
  logic        err_o [2];
`ifdef HAZ_PERF_EN
  logic [31:0] sc_o  [2];
  logic [31:0] fc_o  [2];
`endif

  int total = 0;
  int bad   = 0;

  // One stimulus cycle: inputs, expected combinational outputs and expected IF/ID per dut.
  typedef struct packed {
    logic [31:0] p;
    logic [31:0] i;
    logic        v;
    logic        s;
    logic        f;
    logic [1:0]  pw;
    logic [1:0]  bx;
    logic [31:0] ep0;
    logic [31:0] ei0;
    logic        ev0;
    logic [31:0] ep1;
    logic [31:0] ei1;
    logic        ev1;
    logic [1:0]  er;
    logic [1:0]  cp;
  } cyc_t;

  typedef struct {
    int          d;
    int          step;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        v;
    logic        err;
    logic        cp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  if_id_stall_reg #(.XLEN(32), .NOP_INSTR(NOP), .FLUSH_CYCLES(1), .MAX_STALL(4)) dut0 (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in), .valid_in(valid_in),
    .SignalPC(sig_pc), .flush(flush), .pc_write(pw_o[0]), .if_id_write(iw_o[0]),
    .bubble_ex(bx_o[0]), .pc_out(pc_o[0]), .instr_out(in_o[0]), .valid_out(v_o[0]),
    .stall_err(err_o[0])
`ifdef HAZ_PERF_EN
    , .stall_count(sc_o[0]), .flush_count(fc_o[0])
`endif
  );

  if_id_stall_reg #(.XLEN(32), .NOP_INSTR(NOP), .FLUSH_CYCLES(2), .MAX_STALL(4)) dut1 (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in), .valid_in(valid_in),
    .SignalPC(sig_pc), .flush(flush), .pc_write(pw_o[1]), .if_id_write(iw_o[1]),
    .bubble_ex(bx_o[1]), .pc_out(pc_o[1]), .instr_out(in_o[1]), .valid_out(v_o[1]),
    .stall_err(err_o[1])
`ifdef HAZ_PERF_EN
    , .stall_count(sc_o[1]), .flush_count(fc_o[1])
`endif
  );

  function automatic cyc_t mk(input logic [31:0] p, i, input logic v, s, f,
                              input logic [1:0] pw, bx,
                              input logic [31:0] ep0, ei0, input logic ev0,
                              input logic [31:0] ep1, ei1, input logic ev1,
                              input logic [1:0] er, cp);
    mk = '{p, i, v, s, f, pw, bx, ep0, ei0, ev0, ep1, ei1, ev1, er, cp};
  endfunction

  task automatic drive(input logic [31:0] p, input logic [31:0] i, input logic v,
                       input logic s, input logic f);
    pc_in = p; instr_in = i; valid_in = v; sig_pc = s; flush = f;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one table row and queue the IF/ID state each dut must show after the next edge.
  task automatic apply(input cyc_t c, input int k);
    drive(c.p, c.i, c.v, c.s, c.f);
    sb.push_back('{0, k, c.ep0, c.ei0, c.ev0, c.er[0], c.cp[0]});
    sb.push_back('{1, k, c.ep1, c.ei1, c.ev1, c.er[1], c.cp[1]});
    #1;
  endtask

  task automatic test_reset;
    drive(32'h55, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    tick;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (pc_o[d] !== 32'h55) begin
        bad++;
        $display("FAIL reset_preload dut%0d got pc=%h want pc=%h", d, pc_o[d], 32'h55);
      end
    end
    #3 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({pc_o[d], in_o[d], v_o[d], err_o[d], pw_o[d], iw_o[d], bx_o[d]} !==
          {32'h0, NOP, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL reset_async dut%0d got pc=%h instr=%h v=%b err=%b pw=%b iw=%b bx=%b want pc=0 instr=%h v=0 err=0 pw=1 iw=1 bx=0",
                 d, pc_o[d], in_o[d], v_o[d], err_o[d], pw_o[d], iw_o[d], bx_o[d], NOP);
      end
    end
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    tick;
  endtask

  task automatic test_pass_through;
    cyc_t t[4];
    exp_t e;
    logic [65:0] got;
    logic [65:0] want;
    t[0] = mk(32'h100, 32'h00A50533, 1, 0, 0, 2'b11, 2'b00, 32'h100, 32'h00A50533, 1, 32'h100, 32'h00A50533, 1, 2'b00, 2'b11);
    t[1] = mk(32'h104, 32'h00B50633, 1, 0, 0, 2'b11, 2'b00, 32'h104, 32'h00B50633, 1, 32'h104, 32'h00B50633, 1, 2'b00, 2'b11);
    t[2] = mk(32'h108, 32'hFFFFFFFF, 0, 0, 0, 2'b11, 2'b00, 32'h108, 32'hFFFFFFFF, 0, 32'h108, 32'hFFFFFFFF, 0, 2'b00, 2'b11);
    t[3] = mk(32'h100, 32'h00A50533, 1, 0, 0, 2'b11, 2'b00, 32'h100, 32'h00A50533, 1, 32'h100, 32'h00A50533, 1, 2'b00, 2'b11);
    for (int k = 0; k < 4; k++) begin
      apply(t[k], k);
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({pw_o[d], iw_o[d], bx_o[d]} !== {t[k].pw[d], t[k].pw[d], t[k].bx[d]}) begin
          bad++;
          $display("FAIL pass_comb c%0d dut%0d got pw/iw/bx=%b%b%b want=%b%b%b", k, d,
                   pw_o[d], iw_o[d], bx_o[d], t[k].pw[d], t[k].pw[d], t[k].bx[d]);
        end
      end
      tick;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        got  = {(e.cp ? pc_o[e.d] : e.pc), in_o[e.d], v_o[e.d], err_o[e.d]};
        want = {e.pc, e.instr, e.v, e.err};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL pass_ifid c%0d dut%0d got pc/instr/v/err=%h want=%h", e.step, e.d, got, want);
        end
      end
    end
  endtask

  task automatic test_load_use;
    cyc_t t[3];
    exp_t e;
    logic [65:0] got;
    logic [65:0] want;
    t[0] = mk(32'h104, 32'h00000123, 1, 1, 0, 2'b00, 2'b11, 32'h100, 32'h00A50533, 1, 32'h100, 32'h00A50533, 1, 2'b00, 2'b11);
    t[1] = mk(32'h104, 32'h00000123, 1, 0, 0, 2'b11, 2'b00, 32'h104, 32'h00000123, 1, 32'h104, 32'h00000123, 1, 2'b00, 2'b11);
    t[2] = mk(32'h108, 32'h00000456, 1, 0, 0, 2'b11, 2'b00, 32'h108, 32'h00000456, 1, 32'h108, 32'h00000456, 1, 2'b00, 2'b11);
    for (int k = 0; k < 3; k++) begin
      apply(t[k], k);
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({pw_o[d], iw_o[d], bx_o[d]} !== {t[k].pw[d], t[k].pw[d], t[k].bx[d]}) begin
          bad++;
          $display("FAIL load_use_comb c%0d dut%0d got pw/iw/bx=%b%b%b want=%b%b%b", k, d,
                   pw_o[d], iw_o[d], bx_o[d], t[k].pw[d], t[k].pw[d], t[k].bx[d]);
        end
      end
      tick;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        got  = {(e.cp ? pc_o[e.d] : e.pc), in_o[e.d], v_o[e.d], err_o[e.d]};
        want = {e.pc, e.instr, e.v, e.err};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL load_use_ifid c%0d dut%0d got pc/instr/v/err=%h want=%h", e.step, e.d, got, want);
        end
      end
    end
  endtask

  // Flush with a simultaneous stall request, then SignalPC held through the FLUSH window.
  task automatic test_flush_vs_stall;
    cyc_t t[4];
    exp_t e;
    logic [65:0] got;
    logic [65:0] want;
    t[0] = mk(32'h200, 32'h00000ABC, 1, 1, 1, 2'b11, 2'b11, 32'h0, NOP, 0, 32'h0, NOP, 0, 2'b00, 2'b00);
    t[1] = mk(32'h204, 32'h00000222, 1, 1, 0, 2'b11, 2'b00, 32'h204, 32'h00000222, 1, 32'h0, NOP, 0, 2'b00, 2'b01);
    t[2] = mk(32'h208, 32'h00000333, 1, 1, 0, 2'b10, 2'b01, 32'h204, 32'h00000222, 1, 32'h208, 32'h00000333, 1, 2'b00, 2'b11);
    t[3] = mk(32'h20C, 32'h00000444, 1, 0, 0, 2'b11, 2'b00, 32'h20C, 32'h00000444, 1, 32'h20C, 32'h00000444, 1, 2'b00, 2'b11);
    for (int k = 0; k < 4; k++) begin
      apply(t[k], k);
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({pw_o[d], iw_o[d], bx_o[d]} !== {t[k].pw[d], t[k].pw[d], t[k].bx[d]}) begin
          bad++;
          $display("FAIL flush_stall_comb c%0d dut%0d got pw/iw/bx=%b%b%b want=%b%b%b", k, d,
                   pw_o[d], iw_o[d], bx_o[d], t[k].pw[d], t[k].pw[d], t[k].bx[d]);
        end
      end
      tick;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        got  = {(e.cp ? pc_o[e.d] : e.pc), in_o[e.d], v_o[e.d], err_o[e.d]};
        want = {e.pc, e.instr, e.v, e.err};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL flush_stall_ifid c%0d dut%0d got pc/instr/v/err=%h want=%h", e.step, e.d, got, want);
        end
      end
    end
  endtask

  // Two flushes back to back: the second restarts the NOP window.
  task automatic test_back_to_back;
    cyc_t t[4];
    exp_t e;
    logic [65:0] got;
    logic [65:0] want;
    t[0] = mk(32'h300, 32'h00000555, 1, 0, 1, 2'b11, 2'b11, 32'h0, NOP, 0, 32'h0, NOP, 0, 2'b00, 2'b00);
    t[1] = mk(32'h304, 32'h00000666, 1, 0, 1, 2'b11, 2'b11, 32'h0, NOP, 0, 32'h0, NOP, 0, 2'b00, 2'b00);
    t[2] = mk(32'h308, 32'h00000777, 1, 0, 0, 2'b11, 2'b00, 32'h308, 32'h00000777, 1, 32'h0, NOP, 0, 2'b00, 2'b01);
    t[3] = mk(32'h30C, 32'h00000888, 1, 0, 0, 2'b11, 2'b00, 32'h30C, 32'h00000888, 1, 32'h30C, 32'h00000888, 1, 2'b00, 2'b11);
    for (int k = 0; k < 4; k++) begin
      apply(t[k], k);
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({pw_o[d], iw_o[d], bx_o[d]} !== {t[k].pw[d], t[k].pw[d], t[k].bx[d]}) begin
          bad++;
          $display("FAIL b2b_comb c%0d dut%0d got pw/iw/bx=%b%b%b want=%b%b%b", k, d,
                   pw_o[d], iw_o[d], bx_o[d], t[k].pw[d], t[k].pw[d], t[k].bx[d]);
        end
      end
      tick;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        got  = {(e.cp ? pc_o[e.d] : e.pc), in_o[e.d], v_o[e.d], err_o[e.d]};
        want = {e.pc, e.instr, e.v, e.err};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL b2b_ifid c%0d dut%0d got pc/instr/v/err=%h want=%h", e.step, e.d, got, want);
        end
      end
    end
  endtask

  task automatic test_watchdog;
    cyc_t t[6];
    exp_t e;
    logic [65:0] got;
    logic [65:0] want;
    t[0] = mk(32'h400, 32'h00009990, 1, 1, 0, 2'b00, 2'b11, 32'h30C, 32'h00000888, 1, 32'h30C, 32'h00000888, 1, 2'b00, 2'b11);
    t[1] = mk(32'h404, 32'h00009991, 1, 1, 0, 2'b00, 2'b11, 32'h30C, 32'h00000888, 1, 32'h30C, 32'h00000888, 1, 2'b00, 2'b11);
    t[2] = mk(32'h408, 32'h00009992, 1, 1, 0, 2'b00, 2'b11, 32'h30C, 32'h00000888, 1, 32'h30C, 32'h00000888, 1, 2'b00, 2'b11);
    t[3] = mk(32'h40C, 32'h00009993, 1, 1, 0, 2'b00, 2'b11, 32'h30C, 32'h00000888, 1, 32'h30C, 32'h00000888, 1, 2'b11, 2'b11);
    t[4] = mk(32'h410, 32'h00000AAA, 1, 0, 0, 2'b11, 2'b00, 32'h410, 32'h00000AAA, 1, 32'h410, 32'h00000AAA, 1, 2'b11, 2'b11);
    t[5] = mk(32'h414, 32'h00000BBB, 1, 0, 0, 2'b11, 2'b00, 32'h414, 32'h00000BBB, 1, 32'h414, 32'h00000BBB, 1, 2'b11, 2'b11);
    for (int k = 0; k < 6; k++) begin
      apply(t[k], k);
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({pw_o[d], iw_o[d], bx_o[d]} !== {t[k].pw[d], t[k].pw[d], t[k].bx[d]}) begin
          bad++;
          $display("FAIL watchdog_comb c%0d dut%0d got pw/iw/bx=%b%b%b want=%b%b%b", k, d,
                   pw_o[d], iw_o[d], bx_o[d], t[k].pw[d], t[k].pw[d], t[k].bx[d]);
        end
      end
      tick;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        got  = {(e.cp ? pc_o[e.d] : e.pc), in_o[e.d], v_o[e.d], err_o[e.d]};
        want = {e.pc, e.instr, e.v, e.err};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL watchdog_ifid c%0d dut%0d got pc/instr/v/err=%h want=%h", e.step, e.d, got, want);
        end
      end
    end
`ifdef HAZ_PERF_EN
    // Stall cycles since reset: load-use 1, flush_vs_stall 1 (dut0 only), watchdog 4; flush cycles 3.
    total++;
    if ({sc_o[0], sc_o[1], fc_o[0], fc_o[1]} !== {32'd6, 32'd5, 32'd3, 32'd3}) begin
      bad++;
      $display("FAIL perf_counts got stall=%0d/%0d flush=%0d/%0d want stall=6/5 flush=3/3",
               sc_o[0], sc_o[1], fc_o[0], fc_o[1]);
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset;
    test_pass_through;
    test_load_use;
    test_flush_vs_stall;
    test_back_to_back;
    test_watchdog;
    test_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
